// File: rtl/msg_seq_ctrl.sv
// msg_seq_ctrl: frame serializer with programmable bit period.
// Sends a FRAME_BITS-wide message latched from SW, MSB- or LSB-first, with
// each bit held for div_q+1 cycles (mode=0) or a single cycle (mode=1).
// Every output is a flop; next-cycle output values are computed one edge ahead.
module msg_seq_ctrl #(
  parameter int FRAME_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  sel,
  input  logic [FRAME_BITS-1:0] SW,
  output logic                  ser_out,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            bit_idx,
  output logic [FRAME_BITS-1:0] div_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]            LAST_IDX = 4'(FRAME_BITS - 1);
  localparam logic [FRAME_BITS-1:0] TIMER_ONE = {{(FRAME_BITS-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] timer_q, timer_d;
  logic [FRAME_BITS-1:0] div_d;
  logic [3:0]            idx_d;
  logic                  mode_q, mode_d;
  logic                  sel_q, sel_d;
  logic                  ser_d, busy_d, done_d;
  logic                  bit_adv;

  // Bit presented on the line for a given shift register and bit order.
  function automatic logic out_bit(input logic [FRAME_BITS-1:0] sh,
                                   input logic lsb_first);
    return lsb_first ? sh[0] : sh[FRAME_BITS-1];
  endfunction

  // Shift one position toward whichever end feeds the line.
  function automatic logic [FRAME_BITS-1:0] shift_out(input logic [FRAME_BITS-1:0] sh,
                                                      input logic lsb_first);
    return lsb_first ? {1'b0, sh[FRAME_BITS-1:1]} : {sh[FRAME_BITS-2:0], 1'b0};
  endfunction

  // A bit completes every cycle in fast mode, otherwise when the timer hits div_q.
  assign bit_adv = mode_q || (timer_q == div_q);

  // Next-state and next-output logic; outputs are precomputed so they leave flops.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    timer_d = timer_q;
    div_d   = div_q;
    idx_d   = bit_idx;
    mode_d  = mode_q;
    sel_d   = sel_q;
    ser_d   = ser_out;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        ser_d  = 1'b1;
        if (init) begin
          // init wins over a simultaneous start
          div_d = SW;
        end else if (start) begin
          shift_d = SW;
          mode_d  = mode;
          sel_d   = sel;
          idx_d   = 4'd0;
          timer_d = '0;
          busy_d  = 1'b1;
          ser_d   = out_bit(SW, sel);
          state_d = SEND;
        end
      end
      SEND: begin
        if (bit_adv) begin
          timer_d = '0;
          if (bit_idx == LAST_IDX) begin
            // Final bit done: hold bit_idx, idle the line, pulse done.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ser_d   = 1'b1;
            state_d = DONE;
          end else begin
            shift_d = shift_out(shift_q, sel_q);
            idx_d   = bit_idx + 4'd1;
            ser_d   = out_bit(shift_d, sel_q);
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        ser_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        ser_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset returns everything to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      timer_q <= '0;
      div_q   <= '0;
      bit_idx <= 4'd0;
      mode_q  <= 1'b0;
      sel_q   <= 1'b0;
      ser_out <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      bit_idx <= idx_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      ser_out <= ser_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_msg_seq_ctrl.sv
// Scoreboard bench for msg_seq_ctrl: stimulus pushes expected line cycles,
// a negedge monitor pops and compares whenever busy or done is presented.
module tb_msg_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       sel = 1'b0;
  logic [9:0] SW = '0;
  logic       ser_out, busy, done;
  logic [3:0] bit_idx;
  logic [9:0] div_q;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_done;
    logic       b;
    logic [3:0] idx;
  } exp_t;

  exp_t q[$];

  msg_seq_ctrl #(.FRAME_BITS(10)) dut (
    .clk(clk), .rst(rst), .init(init), .start(start), .mode(mode), .sel(sel),
    .SW(SW), .ser_out(ser_out), .busy(busy), .done(done), .bit_idx(bit_idx),
    .div_q(div_q)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d queued, required 0", q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every busy or done cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && (busy || done)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got busy=%0b done=%0b idx=%0d, required no activity",
                 busy, done, bit_idx);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.is_done) begin
          if (!(done && !busy && ser_out)) begin
            errors++;
            $display("FAIL done_cycle: got done=%0b busy=%0b ser=%0b, required done=1 busy=0 ser=1",
                     done, busy, ser_out);
          end
        end else if (!(busy && !done && ser_out == e.b && bit_idx == e.idx)) begin
          errors++;
          $display("FAIL bit_cycle: got busy=%0b done=%0b ser=%0b idx=%0d, required busy=1 done=0 ser=%0b idx=%0d",
                   busy, done, ser_out, bit_idx, e.b, e.idx);
        end
      end
    end
  end

  // seq[9] is the first bit expected on the line; each bit lasts p cycles.
  task automatic push_seq(input logic [9:0] seq, input int p);
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < p; k++) begin
        e.is_done = 1'b0;
        e.b       = seq[9-i];
        e.idx     = 4'(i);
        q.push_back(e);
      end
    end
    e.is_done = 1'b1;
    e.b       = 1'b1;
    e.idx     = 4'd0;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] sw, input logic m, input logic s,
                      input logic [9:0] seq, input int p);
    SW = sw; mode = m; sel = s; start = 1'b1;
    push_seq(seq, p);
    tick();
    start = 1'b0;
    chk("start_latency_busy", busy, 1);
    chk("start_idx0", bit_idx, 0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((q.size() != 0 || busy || done) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got %0d entries left, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic do_init(input logic [9:0] v);
    SW = v; init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_div", div_q, 32'(v));
  endtask

  initial begin
    int n;
    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_ser", ser_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", bit_idx, 0);
    chk("rst_div", div_q, 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();

    // MSB first, one bit per clock
    send(10'b1001101101, 1'b1, 1'b0, 10'b1001101101, 1);
    wait_idle("msb_fast", 100);

    // LSB first
    send(10'b1001101101, 1'b1, 1'b1, 10'b1011011001, 1);
    wait_idle("lsb_fast", 100);

    // init and start together: only init acts
    SW = 10'd5; init = 1'b1; start = 1'b1; mode = 1'b1;
    tick();
    init = 1'b0; start = 1'b0;
    chk("init_start_div", div_q, 5);
    chk("init_start_busy", busy, 0);
    repeat (3) tick();
    chk("init_start_still_idle", busy, 0);

    // Divisor 3: each bit held 4 cycles, 40 busy cycles
    do_init(10'd3);
    send(10'b1100101011, 1'b0, 1'b0, 10'b1100101011, 4);
    wait_idle("div3", 200);

    // Mid-frame start, sel, mode, init and SW changes are ignored
    send(10'b0110011101, 1'b1, 1'b0, 10'b0110011101, 1);
    tick();
    start = 1'b1; SW = 10'h3ff;
    tick();
    start = 1'b0; sel = 1'b1; mode = 1'b0;
    init = 1'b1; SW = 10'd7;
    tick();
    init = 1'b0;
    wait_idle("ignore_midframe", 100);
    chk("div_kept", div_q, 3);
    repeat (3) tick();
    chk("no_restart", busy, 0);

    // Divisor 0 in paced mode behaves like one bit per clock
    do_init(10'd0);
    send(10'b1010000111, 1'b0, 1'b1, 10'b1110000101, 1);
    wait_idle("div0", 100);

    // start held high: next frame begins right after the IDLE cycle following DONE
    SW = 10'b1100101000; mode = 1'b1; sel = 1'b0; start = 1'b1;
    push_seq(10'b1100101000, 1);
    push_seq(10'b1100101000, 1);
    tick();
    chk("held_first_busy", busy, 1);
    n = 0;
    while (!done && n < 50) begin tick(); n++; end
    chk("held_done_seen", done, 1);
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    chk("held_restart_gap", n, 2);
    start = 1'b0;
    wait_idle("held", 100);

    // Reset mid-frame at bit 4 aborts without a done pulse
    send(10'b1111100000, 1'b1, 1'b0, 10'b1111100000, 1);
    n = 0;
    while (bit_idx != 4'd4 && n < 20) begin tick(); n++; end
    chk("abort_reached_idx4", bit_idx, 4);
    rst = 1'b0;
    #1;
    chk("abort_ser", ser_out, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_idx", bit_idx, 0);
    chk("abort_div", div_q, 0);
    q.delete();
    tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("abort_no_done", done, 0);
    send(10'b1000110011, 1'b1, 1'b0, 10'b1000110011, 1);
    wait_idle("after_abort", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_seq_ctrl.md
MSG_SEQ_CTRL -- requirements
Module: msg_seq_ctrl

Interface
REQ-001 Parameter: FRAME_BITS, 10, number of message bits per frame; also the width of SW.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 init  in  1  configure strobe; loads the bit-period divisor from SW.
REQ-005 start  in  1  send request; latches SW as the message.
REQ-006 mode  in  1  pacing select: 0 = divisor-paced, 1 = one bit per clock.
REQ-007 sel  in  1  bit order: 0 = MSB first, 1 = LSB first.
REQ-008 SW  in  FRAME_BITS  switch data; divisor on init, message on start.
REQ-009 ser_out  out  1  serial data, idle level 1.
REQ-010 busy  out  1  high while a frame is being sent.
REQ-011 done  out  1  one-cycle pulse after the last bit.
REQ-012 bit_idx  out  4  index of the bit currently on ser_out (0..FRAME_BITS-1).
REQ-013 div_q  out  FRAME_BITS  current divisor register.

Function
REQ-014 States SHALL be IDLE, SEND and DONE, encoded in a registered state variable.
REQ-015 All outputs SHALL be driven only from registers, with no combinational path from any input.
REQ-016 In IDLE with init=1, div_q SHALL take SW at the next edge; init outside IDLE SHALL be ignored.
REQ-017 In IDLE with start=1 and init=0, the block SHALL load SW into the shift register, latch mode and sel, clear bit_idx and the bit timer, and enter SEND.
REQ-018 In IDLE with init=1 and start=1 in the same cycle, only init SHALL take effect.
REQ-019 In SEND, busy=1 and ser_out SHALL equal shift[FRAME_BITS-1] when the latched sel=0, and shift[0] when sel=1.
REQ-020 With latched mode=0, each bit SHALL be held for div_q+1 cycles; the timer counts 0..div_q and advances the bit at div_q.
REQ-021 With latched mode=1, each bit SHALL be held for exactly 1 cycle, regardless of div_q.
REQ-022 On each bit advance, the shift register SHALL shift toward the output end and bit_idx SHALL increment.
REQ-023 When bit FRAME_BITS-1 completes, the block SHALL enter DONE and SHALL NOT wrap bit_idx to 0 within the frame.
REQ-024 DONE SHALL last exactly 1 cycle with done=1, busy=0 and ser_out=1, then return to IDLE.
REQ-025 start, init, mode, sel and SW changes during SEND or DONE SHALL be ignored.
REQ-026 div_q=0 with mode=0 SHALL behave identically to mode=1.
REQ-027 Latency: start sampled at edge N gives busy=1 for cycles N+1 .. N+FRAME_BITS*(P), where P = div_q+1 (mode=0) or 1 (mode=1); done=1 in the following cycle.
REQ-028 A start held high continuously SHALL begin a new frame at the first IDLE cycle after DONE.

Reset
REQ-029 rst=0 SHALL immediately force: state IDLE, ser_out=1, busy=0, done=0, bit_idx=0, div_q=0, shift register=0 and timer=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no done pulse; the first start after reset release sends a complete new frame.
REQ-031 Reset release SHALL take effect on the next rising edge of clk.

Verification
REQ-032 Reset, then mode=1, sel=0, SW=10'b1001101101, start for 1 cycle -> ser_out shows 1,0,0,1,1,0,1,1,0,1 over 10 consecutive cycles, bit_idx 0..9, then done pulse for 1 cycle.
REQ-033 Same SW with sel=1 -> ser_out shows 1,0,1,1,0,1,1,0,0,1 (LSB first).
REQ-034 init with SW=3, then mode=0 and start -> each bit is held 4 cycles, busy is high for 40 cycles, done follows.
REQ-035 init and start high in the same cycle with SW=5 -> div_q=5, state stays IDLE, busy stays 0.
REQ-036 start pulsed again during SEND, and sel toggled mid-frame -> the frame is unchanged and no restart occurs.
REQ-037 rst=0 at bit_idx=4 -> outputs go to reset values immediately and no done pulse occurs; a new start then sends the full 10 bits.
